// File: rtl/factorial_core_slave_if.sv
// Single-cycle register bus between a master and the factorial engine,
// plus the engine's interrupt line back to the master.
interface factorial_core_slave_if #(
    parameter int ADDR_W = 3
);
    logic              s_sel;
    logic              s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [63:0]       s_din;
    logic [63:0]       s_dout;
    logic              interrupt;

    modport master (
        output s_sel, s_wr, s_addr, s_din,
        input  s_dout, interrupt
    );

    modport slave (
        input  s_sel, s_wr, s_addr, s_din,
        output s_dout, interrupt
    );
endinterface

// File: rtl/factorial_core_slave.sv
// Bus-responder factorial engine: computes OPERAND! (mod 2^128) with a
// radix-2 shift-add multiplier, one multiplier bit per clock.
module factorial_core_slave #(
    parameter int ADDR_W      = 3,
    parameter int STEP_CYCLES = 64
) (
    input logic                    clk,
    input logic                    reset_n,
    factorial_core_slave_if.slave  bus
);
    localparam logic [ADDR_W-1:0] A_OPSTART  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_OPCLEAR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_OPDONE   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_INTRPTEN = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_OPERAND  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_RESULTH  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_RESULTL  = ADDR_W'(6);
    localparam logic [5:0]        LAST_STEP  = 6'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INIT, MUL, UPDATE, DONE} state_t;

    state_t         state;
    logic [63:0]    operand;
    logic [63:0]    n;
    logic [127:0]   result;
    logic [127:0]   acc;
    logic [5:0]     step;
    logic           done;
    logic           inten;
    logic [63:0]    dout;

    logic           wr_xfer;
    logic           rd_xfer;
    logic           start_req;
    logic           clear_req;
    logic           busy;
    logic [63:0]    rdata;

    assign wr_xfer   = bus.s_sel & bus.s_wr;
    assign rd_xfer   = bus.s_sel & ~bus.s_wr;
    assign start_req = wr_xfer & (bus.s_addr == A_OPSTART) & bus.s_din[0];
    assign clear_req = wr_xfer & (bus.s_addr == A_OPCLEAR) & bus.s_din[0];
    assign busy      = (state == INIT) | (state == MUL) | (state == UPDATE);

    assign bus.s_dout    = dout;
    assign bus.interrupt = done & inten;

    always_comb begin
        rdata = '0;
        case (bus.s_addr)
            A_OPDONE:   rdata = {62'd0, busy, done};
            A_INTRPTEN: rdata = {63'd0, inten};
            A_OPERAND:  rdata = operand;
            A_RESULTH:  rdata = result[127:64];
            A_RESULTL:  rdata = result[63:0];
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            operand <= '0;
            n       <= '0;
            result  <= '0;
            acc     <= '0;
            step    <= '0;
            done    <= 1'b0;
            inten   <= 1'b0;
            dout    <= '0;
        end else begin
            dout <= rd_xfer ? rdata : 64'd0;
            if (wr_xfer && bus.s_addr == A_INTRPTEN)
                inten <= bus.s_din[0];
            if (wr_xfer && bus.s_addr == A_OPERAND && !busy)
                operand <= bus.s_din;

            // Clear overrides every FSM transition, including DONE entry.
            if (clear_req) begin
                state  <= IDLE;
                n      <= '0;
                result <= '0;
                acc    <= '0;
                step   <= '0;
                done   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_req) begin
                            n     <= operand;
                            state <= INIT;
                        end
                    end
                    INIT: begin
                        result <= 128'd1;
                        acc    <= '0;
                        step   <= '0;
                        if (n <= 64'd1) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                    MUL: begin
                        if (n[step])
                            acc <= acc + (result << step);
                        step <= step + 6'd1;
                        if (step == LAST_STEP)
                            state <= UPDATE;
                    end
                    UPDATE: begin
                        result <= acc;
                        n      <= n - 64'd1;
                        acc    <= '0;
                        step   <= '0;
                        if ((n - 64'd1) <= 64'd1) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                    DONE: done <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
